// File: rtl/conv_pkg.sv
// Shared convolution datapath constants and the result FIFO entry layout.
package conv_pkg;

  localparam int BIT_WIDTH = 8;
  localparam int IN_WIDTH  = 8;
  localparam int COL       = 4;
  localparam int OUT_WIDTH = 20;

  // Position tag stored alongside every buffered result word.
  typedef struct packed {
    logic eol;
    logic eof;
  } conv_tag_t;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic                 eol;
    logic                 eof;
  } conv_entry_t;

endpackage

// File: rtl/conv_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; read data is zero while empty.
module conv_sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/conv_result_collector.sv
// Buffers conv engine results, tags row/frame boundaries and counts words
// dropped because the engine cannot be stalled.
module conv_result_collector #(
  parameter int OUT_WIDTH = conv_pkg::OUT_WIDTH,
  parameter int DEPTH     = 8,
  parameter int OUT_COLS  = 4,
  parameter int OUT_ROWS  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [OUT_WIDTH-1:0]     result,
  input  logic                     valid,
  input  logic                     clear,
  output logic [OUT_WIDTH-1:0]     m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_eol,
  output logic                     m_eof,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  import conv_pkg::*;

  localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_ROWS - 1);

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    conv_tag_t            tag;
  } entry_t;

  // Output handshake: a word transfers on every posedge where m_valid and
  // m_ready are both 1; m_data/m_eol/m_eof hold while m_valid=1 and m_ready=0,
  // and m_valid never depends combinationally on valid.
  entry_t        wr_entry;
  entry_t        rd_entry;
  logic          full;
  logic          empty;
  logic          pop;
  logic          drop;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;

  // A clear coinciding with valid tags that word as the first of a frame.
  assign col_cur = clear ? '0 : col;
  assign row_cur = clear ? '0 : row;

  assign wr_entry.data    = result;
  assign wr_entry.tag.eol = (col_cur == COL_LAST);
  assign wr_entry.tag.eof = (col_cur == COL_LAST) && (row_cur == ROW_LAST);

  assign m_valid = ~empty;
  assign pop     = m_valid & m_ready;
  assign drop    = valid & full & ~pop;

  assign m_data = rd_entry.data;
  assign m_eol  = rd_entry.tag.eol;
  assign m_eof  = rd_entry.tag.eof;

  conv_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (valid),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Position advances on every valid cycle, dropped words included, so tags
  // stay aligned with the engine's raster order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (valid) begin
      if (col_cur == COL_LAST) begin
        col <= '0;
        row <= (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col <= col_cur + 1'b1;
        row <= row_cur;
      end
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= drop;
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector at default parameters.
module tb_conv_result_collector;

  logic        clk;
  logic        rstn;
  logic [19:0] result;
  logic        valid;
  logic        clear;
  logic [19:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_eol;
  logic        m_eof;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  conv_result_collector dut (
    .clk      (clk),
    .rstn     (rstn),
    .result   (result),
    .valid    (valid),
    .clear    (clear),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_eol    (m_eol),
    .m_eof    (m_eof),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: apply inputs, advance one edge, settle
  task automatic drive(input logic v, input logic [19:0] d, input logic r);
    valid   = v;
    result  = d;
    m_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid = 1'b0; clear = 1'b0; m_ready = 1'b0; result = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ((m_valid !== 1'b0) || (m_data !== 20'd0) || (m_eol !== 1'b0) || (m_eof !== 1'b0)) begin
      errors++;
      $display("FAIL reset_out: m_valid=%b m_data=%0h eol=%b eof=%b, need all 0", m_valid, m_data, m_eol, m_eof);
    end
    checks++;
    if ((level !== 4'd0) || (overflow !== 1'b0) || (drop_cnt !== 16'd0)) begin
      errors++;
      $display("FAIL reset_status: level=%0d overflow=%b drop_cnt=%0d, need 0", level, overflow, drop_cnt);
    end
    rstn = 1'b1;
    drive(0, 0, 0);
  endtask

  task automatic test_stream();
    int got = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) begin
        checks++;
        if (m_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_latency: m_valid=%b one cycle after first write, need 1", m_valid);
        end
      end
      if (m_valid === 1'b1) begin
        got++;
        checks++;
        if (m_data !== 20'(got)) begin
          errors++;
          $display("FAIL stream_data: got %0d need %0d", m_data, got);
        end
        checks++;
        if ((m_eol !== ((got % 4) == 0)) || (m_eof !== (got == 16))) begin
          errors++;
          $display("FAIL stream_tags: word %0d eol=%b eof=%b", got, m_eol, m_eof);
        end
      end
      drive(c < 16, 20'(c + 1), 1'b1);
    end
    checks++;
    if ((got != 16) || (m_valid !== 1'b0) || (level !== 4'd0)) begin
      errors++;
      $display("FAIL stream_count: words=%0d m_valid=%b level=%0d, need 16/0/0", got, m_valid, level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin
        checks++;
        if ((level !== 4'd8) || (overflow !== 1'b0)) begin
          errors++;
          $display("FAIL ovf_full: level=%0d overflow=%b, need 8/0", level, overflow);
        end
      end
      drive(1'b1, 20'(101 + i), 1'b0);
    end
    valid = 1'b0;
    checks++;
    if ((level !== 4'd8) || (overflow !== 1'b1) || (drop_cnt !== 16'd2)) begin
      errors++;
      $display("FAIL ovf_status: level=%0d overflow=%b drop_cnt=%0d, need 8/1/2", level, overflow, drop_cnt);
    end
    checks++;
    if ((m_valid !== 1'b1) || (m_data !== 20'd101)) begin
      errors++;
      $display("FAIL ovf_hold: m_valid=%b m_data=%0d, need 1/101", m_valid, m_data);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ((m_valid !== 1'b1) || (m_data !== 20'(101 + i)) || (m_eol !== (i == 3 || i == 7)) || (m_eof !== 1'b0)) begin
        errors++;
        $display("FAIL ovf_drain: idx %0d got v=%b d=%0d eol=%b eof=%b need d=%0d", i, m_valid, m_data, m_eol, m_eof, 101 + i);
      end
      drive(1'b0, 20'd0, 1'b1);
    end
    checks++;
    if ((m_valid !== 1'b0) || (overflow !== 1'b1) || (drop_cnt !== 16'd2)) begin
      errors++;
      $display("FAIL ovf_after: m_valid=%b overflow=%b drop_cnt=%0d, need 0/1/2", m_valid, overflow, drop_cnt);
    end
  endtask

  task automatic test_clear();
    // frame position continues at col 2/row 2 from the previous scenario
    for (int i = 0; i < 9; i++) drive(1'b1, 20'(201 + i), 1'b0);
    checks++;
    if ((drop_cnt !== 16'd3) || (overflow !== 1'b1) || (level !== 4'd8)) begin
      errors++;
      $display("FAIL clr_before: drop_cnt=%0d overflow=%b level=%0d, need 3/1/8", drop_cnt, overflow, level);
    end
    clear = 1'b1;
    drive(1'b0, 20'd0, 1'b0);
    clear = 1'b0;
    checks++;
    if ((overflow !== 1'b0) || (drop_cnt !== 16'd0) || (level !== 4'd8)) begin
      errors++;
      $display("FAIL clr_after: overflow=%b drop_cnt=%0d level=%0d, need 0/0/8", overflow, drop_cnt, level);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ((m_valid !== 1'b1) || (m_data !== 20'(201 + i)) || (m_eol !== (i == 1 || i == 5)) || (m_eof !== (i == 5))) begin
        errors++;
        $display("FAIL clr_drain: idx %0d got v=%b d=%0d eol=%b eof=%b need d=%0d", i, m_valid, m_data, m_eol, m_eof, 201 + i);
      end
      drive(1'b0, 20'd0, 1'b1);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) drive(1'b1, 20'(301 + i), 1'b0);
    checks++;
    if ((level !== 4'd8) || (drop_cnt !== 16'd0)) begin
      errors++;
      $display("FAIL rw_fill: level=%0d drop_cnt=%0d, need 8/0", level, drop_cnt);
    end
    drive(1'b1, 20'd309, 1'b1);
    valid = 1'b0;
    checks++;
    if ((level !== 4'd8) || (drop_cnt !== 16'd0) || (overflow !== 1'b0) || (m_data !== 20'd302)) begin
      errors++;
      $display("FAIL rw_same_cycle: level=%0d drop_cnt=%0d overflow=%b m_data=%0d, need 8/0/0/302", level, drop_cnt, overflow, m_data);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ((m_valid !== 1'b1) || (m_data !== 20'(302 + i)) || (m_eol !== (i == 2 || i == 6)) || (m_eof !== 1'b0)) begin
        errors++;
        $display("FAIL rw_drain: idx %0d got v=%b d=%0d eol=%b eof=%b need d=%0d", i, m_valid, m_data, m_eol, m_eof, 302 + i);
      end
      drive(1'b0, 20'd0, 1'b1);
    end
  endtask

  task automatic test_toggle();
    int          got = 0;
    logic        stalled = 1'b0;
    logic [19:0] held = '0;
    logic        r;
    clear = 1'b1;
    drive(1'b0, 20'd0, 1'b0);
    clear = 1'b0;
    for (int c = 0; (c < 40) && (got < 12); c++) begin
      r = (c % 2 == 1);
      if (stalled) begin
        checks++;
        if ((m_valid !== 1'b1) || (m_data !== held)) begin
          errors++;
          $display("FAIL tog_stable: m_valid=%b m_data=%0d, need 1/%0d", m_valid, m_data, held);
        end
      end
      if ((m_valid === 1'b1) && r) begin
        checks++;
        if ((m_data !== 20'(401 + got)) || (m_eol !== (((got + 1) % 4) == 0)) || (m_eof !== 1'b0)) begin
          errors++;
          $display("FAIL tog_data: got d=%0d eol=%b eof=%b need d=%0d", m_data, m_eol, m_eof, 401 + got);
        end
        got++;
      end
      stalled = (m_valid === 1'b1) && !r;
      held    = m_data;
      drive(c < 12, 20'(401 + c), r);
    end
    checks++;
    if ((got != 12) || (drop_cnt !== 16'd0) || (m_valid !== 1'b0)) begin
      errors++;
      $display("FAIL tog_count: words=%0d drop_cnt=%0d m_valid=%b, need 12/0/0", got, drop_cnt, m_valid);
    end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    for (int i = 0; i < 6; i++) drive(1'b1, 20'(501 + i), 1'b0);
    valid = 1'b0;
    checks++;
    if (level !== 4'd6) begin
      errors++;
      $display("FAIL rst_mid_fill: level=%0d need 6", level);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ((m_valid !== 1'b0) || (level !== 4'd0) || (m_data !== 20'd0)) begin
      errors++;
      $display("FAIL rst_mid_async: m_valid=%b level=%0d m_data=%0d, need 0/0/0", m_valid, level, m_data);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (m_valid === 1'b1) begin
        got++;
        checks++;
        if ((m_data !== 20'(600 + got)) || (m_eol !== (got == 4)) || (m_eof !== 1'b0)) begin
          errors++;
          $display("FAIL rst_mid_words: got d=%0d eol=%b eof=%b need d=%0d", m_data, m_eol, m_eof, 600 + got);
        end
      end
      drive(c < 4, 20'(601 + c), 1'b1);
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL rst_mid_count: words=%0d need 4", got);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_clear();
    test_full_rw();
    test_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_result_collector.md
CONV_RESULT_COLLECTOR -- requirements
Module: conv_result_collector

Interface
REQ-001 SHALL take parameter OUT_WIDTH, default 20: width of one convolution result word.
REQ-002 SHALL take parameter DEPTH, default 8: FIFO entries, power of two, at least 2.
REQ-003 SHALL take parameter OUT_COLS, default 4: output feature-map columns per row.
REQ-004 SHALL take parameter OUT_ROWS, default 4: output feature-map rows per frame.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port result, input, OUT_WIDTH: conv result word.
REQ-008 SHALL have port valid, input, 1: result qualifier; the conv engine cannot be stalled.
REQ-009 SHALL have port clear, input, 1: synchronous clear of overflow, drop_cnt and position counters.
REQ-010 SHALL have port m_data, output, OUT_WIDTH: buffered result.
REQ-011 SHALL have port m_valid, output, 1: m_data holds a word.
REQ-012 SHALL have port m_ready, input, 1: downstream accepts the word.
REQ-013 SHALL have port m_eol, output, 1: m_data is the last column of a row.
REQ-014 SHALL have port m_eof, output, 1: m_data is the last word of a frame.
REQ-015 SHALL have port level, output, $clog2(DEPTH)+1: current FIFO occupancy.
REQ-016 SHALL have port overflow, output, 1: sticky flag, set when a word is dropped.
REQ-017 SHALL have port drop_cnt, output, 16: saturating count of dropped words.

Function
REQ-018 SHALL write {result, eol, eof} into the FIFO in the cycle that valid=1 and the FIFO is not full.
REQ-019 SHALL accept the write when valid=1, full and m_valid&m_ready all occur in the same cycle; level stays DEPTH.
REQ-020 SHALL drop the word when valid=1, full and no read occurs; overflow is set to 1 and drop_cnt increments, saturating at 0xFFFF.
REQ-021 SHALL advance the col counter (0..OUT_COLS-1) on every valid=1 cycle, including dropped words; on wrap, the row counter (0..OUT_ROWS-1) advances; both wrap to 0.
REQ-022 SHALL tag eol=1 when col==OUT_COLS-1, and eof=1 when additionally row==OUT_ROWS-1.
REQ-023 SHALL assert m_valid in the cycle after a write into an empty FIFO (latency 1, no combinational path from valid to m_valid).
REQ-024 SHALL hold m_data, m_eol and m_eof stable while m_valid=1 and m_ready=0.
REQ-025 SHALL pop one entry per cycle with m_valid=1 and m_ready=1; m_ready with m_valid=0 has no effect.
REQ-026 SHALL support a read and a write in the same cycle at any level; level is then unchanged.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH; full/empty derive from an extra pointer MSB.
REQ-028 SHALL, on clear=1, zero overflow, drop_cnt, col and row; FIFO contents and pointers are preserved, and a coincident valid is tagged as col 0/row 0.
REQ-029 SHALL keep overflow at 1 until clear or reset.

Reset
REQ-030 SHALL, while rstn=0, drive m_valid=0, m_data=0, m_eol=0, m_eof=0, level=0, overflow=0 and drop_cnt=0, and zero the pointers, col and row.
REQ-031 SHALL discard buffered words when reset asserts mid-frame; the first valid after release is tagged col 0/row 0.

Structure
REQ-032 SHALL take OUT_WIDTH defaults and the entry typedef {data, eol, eof} from the shared package conv_pkg, alongside BIT_WIDTH, IN_WIDTH and COL.
REQ-033 SHALL instantiate one sub-module, conv_sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, level); position tagging and drop logic stay in the top module.

Verification
REQ-034 The bench SHALL cover: 16 consecutive valid words 1..16 with m_ready=1 -> 16 words out in order; m_eol on 4, 8, 12, 16; m_eof only on 16.
REQ-035 The bench SHALL cover: m_ready=0 and 10 valid words -> words 1..8 buffered, level=8, overflow=1, drop_cnt=2; then m_ready=1 -> words 1..8 out; m_eol on 4 and 8 only.
REQ-036 The bench SHALL cover: FIFO full, valid=1 and m_ready=1 in the same cycle -> no drop, level stays 8, drop_cnt unchanged.
REQ-037 The bench SHALL cover: m_ready toggling every cycle with continuous valid=1 -> m_data stable during stalls and no lost or duplicated words.
REQ-038 The bench SHALL cover: rstn pulsed low after 6 words -> m_valid=0 and level=0 immediately, and the next 4 words after release give m_eol on the 4th.
REQ-039 The bench SHALL cover: clear pulsed after an overflow -> overflow=0 and drop_cnt=0 next cycle, with the FIFO contents still delivered.
